// File: rtl/lcd_fill_sched.sv
// rtl/lcd_fill_sched.sv - LCD init and rectangle-fill byte sequencer driving a byte-level SPI transmitter
module lcd_fill_sched #(
    parameter int SLPOUT_WAIT = 12_000_000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req,
    input  logic [7:0]  req_x0,
    input  logic [7:0]  req_y0,
    input  logic [7:0]  req_x1,
    input  logic [7:0]  req_y1,
    input  logic [15:0] req_color,
    input  logic        byte_done,
    output logic [7:0]  spi_data,
    output logic        dc,
    output logic        cs,
    output logic        init_done,
    output logic        ready,
    output logic        req_err
);

    localparam int WW = $clog2(SLPOUT_WAIT + 1);

    typedef enum logic [2:0] {
        S_INIT_SLP,
        S_INIT_WAIT,
        S_INIT_CFG,
        S_IDLE,
        S_HDR,
        S_PIX_HI,
        S_PIX_LO
    } state_t;

    state_t         state, state_n;
    logic [3:0]     idx, idx_n;
    logic [WW-1:0]  wait_cnt, wait_n;
    logic [16:0]    pix_cnt, pix_n;
    logic [7:0]     x0_q, y0_q, x1_q, y1_q;
    logic [7:0]     x0_n, y0_n, x1_n, y1_n;
    logic [15:0]    color_q, color_n;
    logic [7:0]     data_n;
    logic           dc_n, cs_n, init_done_n, ready_n, req_err_n;

    logic           bd;
    logic           bad_req;
    logic [8:0]     w_span, h_span;
    logic [16:0]    area;

    // The transmitter only shifts with cs low, so a stray pulse while idle means nothing.
    assign bd      = byte_done & ~cs;
    assign bad_req = (req_x1 < req_x0) | (req_y1 < req_y0);
    assign w_span  = {1'b0, req_x1} - {1'b0, req_x0} + 9'd1;
    assign h_span  = {1'b0, req_y1} - {1'b0, req_y0} + 9'd1;
    assign area    = 17'(w_span) * 17'(h_span);

    function automatic logic [8:0] hdr_byte(input logic [3:0] k, input logic [7:0] xa,
                                            input logic [7:0] xb, input logic [7:0] ya,
                                            input logic [7:0] yb);
        case (k)
            4'd0:    hdr_byte = {1'b0, 8'h2A};
            4'd1:    hdr_byte = {1'b1, 8'h00};
            4'd2:    hdr_byte = {1'b1, xa};
            4'd3:    hdr_byte = {1'b1, 8'h00};
            4'd4:    hdr_byte = {1'b1, xb};
            4'd5:    hdr_byte = {1'b0, 8'h2B};
            4'd6:    hdr_byte = {1'b1, 8'h00};
            4'd7:    hdr_byte = {1'b1, ya};
            4'd8:    hdr_byte = {1'b1, 8'h00};
            4'd9:    hdr_byte = {1'b1, yb};
            4'd10:   hdr_byte = {1'b0, 8'h2C};
            default: hdr_byte = {1'b0, 8'h00};
        endcase
    endfunction

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= S_INIT_SLP;
            idx       <= '0;
            wait_cnt  <= '0;
            pix_cnt   <= '0;
            x0_q      <= '0;
            y0_q      <= '0;
            x1_q      <= '0;
            y1_q      <= '0;
            color_q   <= '0;
            spi_data  <= '0;
            dc        <= 1'b0;
            cs        <= 1'b1;
            init_done <= 1'b0;
            ready     <= 1'b0;
            req_err   <= 1'b0;
        end else begin
            state     <= state_n;
            idx       <= idx_n;
            wait_cnt  <= wait_n;
            pix_cnt   <= pix_n;
            x0_q      <= x0_n;
            y0_q      <= y0_n;
            x1_q      <= x1_n;
            y1_q      <= y1_n;
            color_q   <= color_n;
            spi_data  <= data_n;
            dc        <= dc_n;
            cs        <= cs_n;
            init_done <= init_done_n;
            ready     <= ready_n;
            req_err   <= req_err_n;
        end
    end

    always_comb begin
        state_n = state;
        case (state)
            S_INIT_SLP:  if (bd) state_n = S_INIT_WAIT;
            S_INIT_WAIT: if (wait_cnt == WW'(1)) state_n = S_INIT_CFG;
            S_INIT_CFG:  if (bd && idx == 4'd2) state_n = S_IDLE;
            S_IDLE:      if (req && !bad_req) state_n = S_HDR;
            S_HDR:       if (bd && idx == 4'd10) state_n = S_PIX_HI;
            S_PIX_HI:    if (bd) state_n = S_PIX_LO;
            S_PIX_LO:    if (bd) state_n = (pix_cnt == 17'd1) ? S_IDLE : S_PIX_HI;
            default:     state_n = S_INIT_SLP;
        endcase
    end

    always_comb begin
        idx_n       = idx;
        wait_n      = wait_cnt;
        pix_n       = pix_cnt;
        x0_n        = x0_q;
        y0_n        = y0_q;
        x1_n        = x1_q;
        y1_n        = y1_q;
        color_n     = color_q;
        data_n      = spi_data;
        dc_n        = dc;
        cs_n        = cs;
        init_done_n = init_done;
        ready_n     = ready;
        req_err_n   = 1'b0;
        case (state)
            S_INIT_SLP: begin
                if (bd) begin
                    cs_n   = 1'b1;
                    wait_n = WW'(SLPOUT_WAIT);
                end else begin
                    cs_n   = 1'b0;
                    data_n = 8'h11;
                    dc_n   = 1'b0;
                end
            end
            S_INIT_WAIT: begin
                if (wait_cnt == WW'(1)) begin
                    cs_n   = 1'b0;
                    data_n = 8'h29;
                    dc_n   = 1'b0;
                    idx_n  = '0;
                end else begin
                    wait_n = wait_cnt - WW'(1);
                end
            end
            S_INIT_CFG: begin
                if (bd) begin
                    if (idx == 4'd2) begin
                        cs_n        = 1'b1;
                        init_done_n = 1'b1;
                        ready_n     = 1'b1;
                    end else begin
                        idx_n  = idx + 4'd1;
                        data_n = (idx == 4'd0) ? 8'h3A : 8'h55;
                        dc_n   = (idx != 4'd0);
                    end
                end
            end
            S_IDLE: begin
                if (req) begin
                    if (bad_req) begin
                        req_err_n = 1'b1;
                    end else begin
                        x0_n    = req_x0;
                        y0_n    = req_y0;
                        x1_n    = req_x1;
                        y1_n    = req_y1;
                        color_n = req_color;
                        pix_n   = area;
                        ready_n = 1'b0;
                        cs_n    = 1'b0;
                        data_n  = 8'h2A;
                        dc_n    = 1'b0;
                        idx_n   = '0;
                    end
                end
            end
            S_HDR: begin
                if (bd) begin
                    if (idx == 4'd10) begin
                        data_n = color_q[15:8];
                        dc_n   = 1'b1;
                    end else begin
                        idx_n          = idx + 4'd1;
                        {dc_n, data_n} = hdr_byte(idx + 4'd1, x0_q, x1_q, y0_q, y1_q);
                    end
                end
            end
            S_PIX_HI: begin
                if (bd) begin
                    data_n = color_q[7:0];
                    dc_n   = 1'b1;
                end
            end
            S_PIX_LO: begin
                if (bd) begin
                    pix_n = pix_cnt - 17'd1;
                    if (pix_cnt == 17'd1) begin
                        cs_n    = 1'b1;
                        ready_n = 1'b1;
                    end else begin
                        data_n = color_q[15:8];
                        dc_n   = 1'b1;
                    end
                end
            end
            default: begin
                cs_n = 1'b1;
            end
        endcase
    end

endmodule

// File: tb/tb_lcd_fill_sched.sv
// tb/tb_lcd_fill_sched.sv - scoreboard bench for lcd_fill_sched with a byte_done transmitter model
module tb_lcd_fill_sched;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        req = 1'b0;
    logic [7:0]  req_x0 = '0, req_y0 = '0, req_x1 = '0, req_y1 = '0;
    logic [15:0] req_color = '0;
    logic        byte_done = 1'b0;
    logic [7:0]  spi_data;
    logic        dc, cs, init_done, ready, req_err;

    int          n_cmp = 0;
    int          n_bad = 0;
    int          n_bytes = 0;
    int          ready_viol = 0;
    int          tx_cnt = 0;
    logic [8:0]  exp_q[$];
    logic [8:0]  mon_exp;

    always #5 clk = ~clk;

    lcd_fill_sched #(.SLPOUT_WAIT(16)) dut (
        .clk(clk), .reset(reset), .req(req),
        .req_x0(req_x0), .req_y0(req_y0), .req_x1(req_x1), .req_y1(req_y1),
        .req_color(req_color), .byte_done(byte_done),
        .spi_data(spi_data), .dc(dc), .cs(cs),
        .init_done(init_done), .ready(ready), .req_err(req_err)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic push_init();
        exp_q.push_back({1'b0, 8'h11});
        exp_q.push_back({1'b0, 8'h29});
        exp_q.push_back({1'b0, 8'h3A});
        exp_q.push_back({1'b1, 8'h55});
    endtask

    task automatic push_fill(input logic [7:0] x0, input logic [7:0] x1, input logic [7:0] y0,
                             input logic [7:0] y1, input logic [15:0] col, input int npix);
        exp_q.push_back({1'b0, 8'h2A});
        exp_q.push_back({1'b1, 8'h00});
        exp_q.push_back({1'b1, x0});
        exp_q.push_back({1'b1, 8'h00});
        exp_q.push_back({1'b1, x1});
        exp_q.push_back({1'b0, 8'h2B});
        exp_q.push_back({1'b1, 8'h00});
        exp_q.push_back({1'b1, y0});
        exp_q.push_back({1'b1, 8'h00});
        exp_q.push_back({1'b1, y1});
        exp_q.push_back({1'b0, 8'h2C});
        for (int i = 0; i < npix; i++) begin
            exp_q.push_back({1'b1, col[15:8]});
            exp_q.push_back({1'b1, col[7:0]});
        end
    endtask

    task automatic set_req(input logic [7:0] x0, input logic [7:0] x1, input logic [7:0] y0,
                           input logic [7:0] y1, input logic [15:0] col);
        req_x0    = x0;
        req_x1    = x1;
        req_y0    = y0;
        req_y1    = y1;
        req_color = col;
        req       = 1'b1;
    endtask

    task automatic wait_ready(input string name, input int budget);
        int to = 0;
        while (!ready && to < budget) begin
            @(negedge clk);
            to++;
        end
        if (!ready) begin
            n_cmp++;
            n_bad++;
            $display("FAIL %s: timeout waiting for ready, got 0 expected 1", name);
        end
    endtask

    // Transmitter model: byte_done pulses 8 cycles after each byte is presented.
    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (reset || cs || byte_done) begin
                byte_done = 1'b0;
                tx_cnt    = 0;
            end else begin
                tx_cnt++;
                if (tx_cnt == 8) byte_done = 1'b1;
            end
        end
    end

    // Monitor: every completed byte is checked against the scoreboard queue.
    always @(negedge clk) begin
        if (!reset && !cs && ready) ready_viol++;
        if (!reset && byte_done && !cs) begin
            n_bytes++;
            if (exp_q.size() == 0) begin
                n_cmp++;
                n_bad++;
                $display("FAIL byte_unexpected: got dc=%0d data=0x%0h, expected none", dc, spi_data);
            end else begin
                mon_exp = exp_q.pop_front();
                check($sformatf("byte%0d", n_bytes), 32'({dc, spi_data}), 32'(mon_exp));
            end
        end
    end

    initial begin
        int hi;
        int to;
        int base;
        repeat (3) @(negedge clk);
        check("rst_cs", 32'(cs), 32'd1);
        check("rst_dc", 32'(dc), 32'd0);
        check("rst_data", 32'(spi_data), 32'd0);
        check("rst_init_done", 32'(init_done), 32'd0);
        check("rst_ready", 32'(ready), 32'd0);
        check("rst_req_err", 32'(req_err), 32'd0);

        push_init();
        reset = 1'b0;
        @(negedge clk);
        check("slpout_cs", 32'(cs), 32'd0);
        check("slpout_data", 32'(spi_data), 32'h11);
        to = 0;
        while (!cs && to < 200) begin
            @(negedge clk);
            to++;
        end
        hi = 0;
        while (cs && hi < 100) begin
            hi++;
            @(negedge clk);
        end
        check("slpout_wait_cycles", 32'(hi), 32'd16);
        to = 0;
        while (!init_done && to < 300) begin
            @(negedge clk);
            to++;
        end
        check("init_done", 32'(init_done), 32'd1);
        check("init_ready", 32'(ready), 32'd1);
        check("init_queue_empty", 32'(exp_q.size()), 32'd0);

        // Fill 1, then fill 2 held on req (with new fields) throughout fill 1.
        ready_viol = 0;
        push_fill(8'd5, 8'd5, 8'd7, 8'd7, 16'hF800, 1);
        push_fill(8'd2, 8'd3, 8'd0, 8'd2, 16'h07E0, 6);
        set_req(8'd5, 8'd5, 8'd7, 8'd7, 16'hF800);
        @(negedge clk);
        check("fill1_ready_drop", 32'(ready), 32'd0);
        check("fill1_cs_low", 32'(cs), 32'd0);
        set_req(8'd2, 8'd3, 8'd0, 8'd2, 16'h07E0);
        wait_ready("fill1_end", 500);
        check("gap_cs_high", 32'(cs), 32'd1);
        @(negedge clk);
        check("b2b_cs_low", 32'(cs), 32'd0);
        check("b2b_ready_low", 32'(ready), 32'd0);
        req = 1'b0;
        wait_ready("fill2_end", 1000);
        check("fill2_cs_high", 32'(cs), 32'd1);
        check("fill_queue_empty", 32'(exp_q.size()), 32'd0);
        check("ready_low_while_busy", 32'(ready_viol), 32'd0);

        // Malformed request.
        set_req(8'd9, 8'd4, 8'd0, 8'd0, 16'hFFFF);
        @(negedge clk);
        req = 1'b0;
        check("rej_req_err", 32'(req_err), 32'd1);
        check("rej_ready", 32'(ready), 32'd1);
        check("rej_cs", 32'(cs), 32'd1);
        @(negedge clk);
        check("rej_req_err_pulse", 32'(req_err), 32'd0);
        check("rej_cs_after", 32'(cs), 32'd1);

        // Reset during the pixel stream.
        push_fill(8'd0, 8'd1, 8'd0, 8'd0, 16'h1234, 2);
        base = n_bytes;
        set_req(8'd0, 8'd1, 8'd0, 8'd0, 16'h1234);
        @(negedge clk);
        req = 1'b0;
        to = 0;
        while (n_bytes < base + 14 && to < 500) begin
            @(negedge clk);
            to++;
        end
        check("pre_reset_bytes", 32'(n_bytes - base), 32'd14);
        @(posedge clk);
        #2;
        check("pre_reset_cs", 32'(cs), 32'd0);
        reset = 1'b1;
        #1;
        check("async_reset_cs", 32'(cs), 32'd1);
        check("async_reset_init_done", 32'(init_done), 32'd0);
        exp_q.delete();
        push_init();
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        check("replay_data", 32'(spi_data), 32'h11);
        check("replay_init_done_low", 32'(init_done), 32'd0);
        to = 0;
        while (!init_done && to < 300) begin
            @(negedge clk);
            to++;
        end
        check("replay_init_done", 32'(init_done), 32'd1);
        check("replay_queue_empty", 32'(exp_q.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/lcd_fill_sched.md
Name: lcd_fill_sched

Overview:
- Sequencer that owns the byte-level SPI transmitter feeding the ST7735-class LCD.
- After reset it runs the panel init sequence: SLPOUT, wait, DISPON, COLMOD = RGB565.
- It then accepts rectangle-fill requests and emits the CASET, RASET and RAMWR commands followed by the RGB565 pixel stream.
- It drives the transmitter's data, D/C and chip-select inputs, and advances on the transmitter's byte-complete pulse.

Parameters:
- SLPOUT_WAIT, 12_000_000: clock cycles with cs high after SLPOUT completes (120 ms at 100 MHz); must be ≥1. Benches override it to 16.

Ports:
- clk, input, 1: system clock.
- reset, input, 1: asynchronous, active-high reset.
- req, input, 1: fill request; sampled only while ready=1.
- req_x0, input, 8: first column.
- req_y0, input, 8: first row.
- req_x1, input, 8: last column.
- req_y1, input, 8: last row.
- req_color, input, 16: RGB565 fill colour.
- byte_done, input, 1: one-cycle pulse from the SPI transmitter when a byte finishes shifting.
- spi_data, output, 8: byte presented to the transmitter.
- dc, output, 1: 0 = command byte, 1 = parameter/pixel byte.
- cs, output, 1: LCD chip select, active low; the transmitter shifts only while cs=0.
- init_done, output, 1: sticky high once init completes.
- ready, output, 1: equals init_done & idle.
- req_err, output, 1: one-cycle pulse when a malformed request is rejected.

Behaviour:
- Reset values: cs=1, dc=0, spi_data=0, init_done=0, ready=0, req_err=0. State = INIT_SLP. Every counter is cleared. Reset asserted mid-transfer forces cs=1 immediately and restarts init on release.
- General rule: all outputs are registered.
  - Each byte's spi_data and dc are valid from the cycle cs falls, or from the cycle after the previous byte_done.
  - On the byte_done of the last byte in a transaction, cs=1 on the next cycle.
  - byte_done while cs=1 is ignored.
- INIT_SLP:
  - First cycle after reset release: cs=0, spi_data=0x11, dc=0.
  - On byte_done: cs=1 and load the wait counter; go to INIT_WAIT.
- INIT_WAIT:
  - cs stays high for exactly SLPOUT_WAIT cycles.
  - Then cs=0 and go to INIT_CFG.
- INIT_CFG:
  - Bytes: 0x29 (dc=0), 0x3A (dc=0), 0x55 (dc=1). Each byte advances on byte_done.
  - On the final byte_done: cs=1, init_done=1, go to IDLE.
- IDLE (ready=1):
  - A request with req=1 and (x1<x0 or y1<y0) is rejected: req_err pulses for 1 cycle, the block stays in IDLE and cs stays high.
  - Otherwise the request is accepted. All req_* fields are latched and ready drops in the same cycle.
  - Pixel count is computed as (x1−x0+1)*(y1−y0+1), 17 bits wide, range 1..65536.
  - Next cycle: cs=0, state = HDR.
- HDR: 11 bytes, indexed by a 4-bit counter:
  - 0x2A (dc=0); then 0x00, x0, 0x00, x1 (dc=1).
  - 0x2B (dc=0); then 0x00, y0, 0x00, y1 (dc=1).
  - 0x2C (dc=0).
  - The 11th byte_done moves to PIX_HI.
- PIX_HI / PIX_LO:
  - Bytes: color[15:8], then color[7:0], both dc=1.
  - Each PIX_LO byte_done decrements the pixel count.
  - At count 0: cs=1, go to IDLE, ready=1 in the same cycle that cs rises.
- Back-to-back requests: a request accepted in the cycle ready returns gives cs high for exactly 1 cycle between transactions.
- req while ready=0 is ignored; there is no queue. Changes to req_* while busy have no effect.
- Total bytes per fill = 11 + 2·pixels.

Test Plan:
- Init (SLPOUT_WAIT=16; transmitter model pulses byte_done 8 cycles after each byte) -> bytes 0x11; cs high for exactly 16 cycles; then 0x29, 0x3A, 0x55; dc pattern 0,0,0,1; init_done=1.
- Fill x0=x1=5, y0=y1=7, color=0xF800 -> 13 bytes in order: 2A 00 05 00 05 2B 00 07 00 07 2C F8 00. dc sequence 0,1,1,1,1,0,1,1,1,1,0,1,1. cs low throughout, high 1 cycle after the last byte_done.
- Fill x0=2, x1=3, y0=0, y1=2, color=0x07E0 -> header then 6 × (07, E0), i.e. 23 bytes total. ready stays low until cs rises.
- Request x0=9, x1=4 -> req_err one-cycle pulse, no cs activity, ready stays 1.
- req pulses during an active fill -> ignored; the byte stream matches the first request exactly.
- Reset asserted after the 3rd pixel byte -> cs=1 in the same cycle (async). After release, the init sequence replays from 0x11 and init_done=0 until it completes.
